// File: rtl/joy_port_pkg.sv
// rtl/joy_port_pkg.sv - shared types and constants for the MSX joystick port A arbiter
package joy_port_pkg;

    typedef enum logic [1:0] {
        NIB_XH = 2'd0,
        NIB_XL = 2'd1,
        NIB_YH = 2'd2,
        NIB_YL = 2'd3
    } nib_state_t;

    localparam int PIN_UP    = 0;
    localparam int PIN_DOWN  = 1;
    localparam int PIN_LEFT  = 2;
    localparam int PIN_RIGHT = 3;
    localparam int PIN_TRGA  = 4;
    localparam int PIN_TRGB  = 5;

    localparam int TIMEOUT_DEFAULT = 100000;

    function automatic nib_state_t nib_next(input nib_state_t s);
        case (s)
            NIB_XH:  return NIB_XL;
            NIB_XL:  return NIB_YH;
            NIB_YH:  return NIB_YL;
            default: return NIB_XH;
        endcase
    endfunction

endpackage

// File: rtl/joy_port_arbiter_sat_acc8.sv
// rtl/joy_port_arbiter_sat_acc8.sv - 8-bit signed saturating accumulator with add/sub and clear
module sat_acc8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_sub,
    input  logic [8:0] i_din,
    output logic [7:0] o_acc
);

    logic        [7:0] r_acc;
    logic        [7:0] w_base;
    logic signed [9:0] w_base_ext;
    logic signed [9:0] w_din_ext;
    logic signed [9:0] w_sum;
    logic        [7:0] w_sat;

    // Clear feeds a zero base so a packet arriving with the clear is kept, not lost.
    always_comb begin
        w_base     = i_clear ? 8'd0 : r_acc;
        w_base_ext = {{2{w_base[7]}}, w_base};
        w_din_ext  = {i_din[8], i_din};
        w_sum      = i_sub ? (w_base_ext - w_din_ext) : (w_base_ext + w_din_ext);
        if (w_sum > 10'sd127) begin
            w_sat = 8'h7F;
        end else if (w_sum < -10'sd128) begin
            w_sat = 8'h80;
        end else begin
            w_sat = w_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 8'd0;
        end else if (i_en) begin
            r_acc <= w_sat;
        end else if (i_clear) begin
            r_acc <= 8'd0;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/joy_port_arbiter.sv
// rtl/joy_port_arbiter.sv - shares MSX port A between MiST joystick and MSX-protocol mouse
module joy_port_arbiter
    import joy_port_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int TO_W           = 18
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [5:0] joy,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [1:0] mouse_btn,
    input  logic       mouse_strobe,
    input  logic       msx_str,
    output logic [5:0] port_pins,
    output logic       mouse_mode
);

    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);

    logic [5:0]      r_pins;
    logic            r_mode;
    nib_state_t      r_state;
    logic [7:0]      r_snap_x;
    logic [7:0]      r_snap_y;
    logic [TO_W-1:0] r_timeout;
    logic            r_str_d;

    logic [7:0] w_acc_x;
    logic [7:0] w_acc_y;
    logic       w_joy_any;
    logic       w_mode_next;
    logic       w_force_xh;
    logic       w_toggle;
    logic       w_acc_clear;
    logic [3:0] w_nibble;
    logic [5:0] w_joy_pins;

    always_comb begin
        w_joy_any   = |joy;
        w_mode_next = mouse_strobe | (~w_joy_any & r_mode);
        w_force_xh  = (w_mode_next != r_mode) | (~mouse_strobe & w_joy_any);
        // Toggles only count while the mouse owns the port and keeps it this cycle.
        w_toggle    = (msx_str ^ r_str_d) & r_mode & w_mode_next;
        w_acc_clear = (mouse_strobe & ~r_mode) | (~mouse_strobe & w_joy_any)
                    | (w_toggle & (r_state == NIB_XH));
    end

    always_comb begin
        case (r_state)
            NIB_XH:  w_nibble = w_acc_x[7:4];
            NIB_XL:  w_nibble = r_snap_x[3:0];
            NIB_YH:  w_nibble = r_snap_y[7:4];
            default: w_nibble = r_snap_y[3:0];
        endcase
    end

    always_comb begin
        w_joy_pins            = 6'd0;
        w_joy_pins[PIN_UP]    = joy[3];
        w_joy_pins[PIN_DOWN]  = joy[2];
        w_joy_pins[PIN_LEFT]  = joy[1];
        w_joy_pins[PIN_RIGHT] = joy[0];
        w_joy_pins[PIN_TRGA]  = joy[4];
        w_joy_pins[PIN_TRGB]  = joy[5];
    end

    // X is negated so that moving right reads as the MSX mouse expects.
    sat_acc8 u_acc_x (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .i_clear (w_acc_clear),
        .i_en    (mouse_strobe),
        .i_sub   (1'b1),
        .i_din   (mouse_x),
        .o_acc   (w_acc_x)
    );

    sat_acc8 u_acc_y (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .i_clear (w_acc_clear),
        .i_en    (mouse_strobe),
        .i_sub   (1'b0),
        .i_din   (mouse_y),
        .o_acc   (w_acc_y)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pins    <= 6'h3F;
            r_mode    <= 1'b0;
            r_state   <= NIB_XH;
            r_snap_x  <= 8'd0;
            r_snap_y  <= 8'd0;
            r_timeout <= '0;
            r_str_d   <= 1'b0;
        end else begin
            r_str_d <= msx_str;
            r_mode  <= w_mode_next;

            if (!w_mode_next) begin
                r_pins <= ~w_joy_pins;
            end else begin
                r_pins[5:4] <= ~mouse_btn;
                if (w_toggle) begin
                    r_pins[3:0] <= w_nibble;
                end
            end

            if (w_force_xh) begin
                r_state  <= NIB_XH;
                r_snap_x <= 8'd0;
                r_snap_y <= 8'd0;
            end else if (w_toggle) begin
                r_state <= nib_next(r_state);
                if (r_state == NIB_XH) begin
                    r_snap_x <= w_acc_x;
                    r_snap_y <= w_acc_y;
                end
            end else if (r_timeout == TO_ONE) begin
                r_state <= NIB_XH;
            end

            if (w_toggle) begin
                r_timeout <= TO_RELOAD;
            end else if (r_timeout != '0) begin
                r_timeout <= r_timeout - TO_ONE;
            end
        end
    end

    assign port_pins  = r_pins;
    assign mouse_mode = r_mode;

endmodule

// File: tb/tb_joy_port_arbiter.sv
// tb/tb_joy_port_arbiter.sv - scoreboard bench for joy_port_arbiter
module tb_joy_port_arbiter;

    localparam int T = 50;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] joy = 6'd0;
    logic [8:0] mouse_x = 9'd0;
    logic [8:0] mouse_y = 9'd0;
    logic [1:0] mouse_btn = 2'd0;
    logic       mouse_strobe = 1'b0;
    logic       msx_str = 1'b0;
    logic [5:0] port_pins;
    logic       mouse_mode;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    joy_port_arbiter #(
        .TIMEOUT_CYCLES (T),
        .TO_W           (18)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .joy          (joy),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_btn    (mouse_btn),
        .mouse_strobe (mouse_strobe),
        .msx_str      (msx_str),
        .port_pins    (port_pins),
        .mouse_mode   (mouse_mode)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin : monitor
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if ({mouse_mode, port_pins} !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got mode=%b pins=%h, expected mode=%b pins=%h",
                         e.name, mouse_mode, port_pins, e.exp[6], e.exp[5:0]);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [6:0] v);
        exp_t e;
        e.name = name;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic expect_nib(input string name, input logic [3:0] nib);
        expect_out(name, {1'b1, ~mouse_btn, nib});
    endtask

    task automatic do_strobe(input logic [8:0] x, input logic [8:0] y);
        mouse_x      = x;
        mouse_y      = y;
        mouse_strobe = 1'b1;
        step();
        mouse_strobe = 1'b0;
    endtask

    task automatic tgl(input string name, input logic [3:0] nib);
        msx_str = ~msx_str;
        step();
        expect_nib(name, nib);
        step(19);
    endtask

    initial begin
        step(2);
        expect_out("reset_hold", 7'h3F);
        step();
        reset_n = 1'b1;
        joy     = 6'b001000;
        step();
        expect_out("joy_up", 7'h3E);
        joy = 6'd0;
        step();
        expect_out("joy_idle", 7'h3F);

        // Mouse read: X=-5, Y=-3
        do_strobe(9'd5, 9'h1FD);
        expect_out("mouse_enter", 7'h7F);
        step(5);
        tgl("rd_xh", 4'hF);
        tgl("rd_xl", 4'hB);
        tgl("rd_yh", 4'hF);
        tgl("rd_yl", 4'hD);

        // Saturation: X=-128, Y=+127
        do_strobe(9'd100, 9'd100);
        step(2);
        do_strobe(9'd100, 9'd100);
        step(5);
        tgl("sat_xh", 4'h8);
        tgl("sat_xl", 4'h0);
        tgl("sat_yh", 4'h7);
        tgl("sat_yl", 4'hF);

        // Timeout returns to XH; reload keeps later toggles in sequence
        do_strobe(9'd5, 9'h1FD);
        step(3);
        tgl("to_a_xh", 4'hF);
        step(T + 2);
        do_strobe(9'd2, 9'd0);
        step(3);
        tgl("to_b_xh", 4'hF);
        step(20);
        tgl("to_c_xl", 4'hE);
        step(20);
        tgl("to_d_yh", 4'h0);
        step(20);
        tgl("to_e_yl", 4'h0);

        // Collision: toggle in XH with strobe x=1
        msx_str      = ~msx_str;
        mouse_x      = 9'd1;
        mouse_y      = 9'd0;
        mouse_strobe = 1'b1;
        step();
        mouse_strobe = 1'b0;
        expect_nib("coll_xh", 4'h0);
        step(19);
        tgl("coll_xl", 4'h0);
        tgl("coll_yh", 4'h0);
        tgl("coll_yl", 4'h0);
        tgl("coll2_xh", 4'hF);
        tgl("coll2_xl", 4'hF);
        tgl("coll2_yh", 4'h0);
        tgl("coll2_yl", 4'h0);

        // Mode switch from NIB_YH
        do_strobe(9'd5, 9'h1FD);
        step(3);
        tgl("ms_pre_xh", 4'hF);
        tgl("ms_pre_xl", 4'hB);
        joy = 6'b010000;
        step();
        expect_out("ms_joy_fire", 7'h2F);
        joy = 6'd0;
        step();
        expect_out("ms_joy_idle", 7'h3F);
        do_strobe(9'h1F0, 9'd0);
        expect_out("ms_reenter", 7'h7F);
        step(5);
        tgl("ms_xh", 4'h1);
        tgl("ms_xl", 4'h0);

        // Buttons follow every cycle in mouse mode
        mouse_btn = 2'b01;
        step();
        expect_out("btn_left", 7'h60);
        mouse_btn = 2'b00;
        step();
        expect_out("btn_none", 7'h70);

        // Same-cycle strobe and joystick: mouse wins, then joystick takes over
        joy          = 6'b000001;
        mouse_x      = 9'd0;
        mouse_y      = 9'd0;
        mouse_strobe = 1'b1;
        step();
        mouse_strobe = 1'b0;
        expect_out("same_cycle", 7'h70);
        step();
        expect_out("joy_right", 7'h37);
        joy = 6'd0;
        step();
        expect_out("joy_release", 7'h3F);

        // Asynchronous reset mid-sequence
        do_strobe(9'd5, 9'h1FD);
        step(3);
        tgl("rm_xh", 4'hF);
        reset_n = 1'b0;
        expect_out("reset_mid", 7'h3F);
        step();
        reset_n = 1'b1;
        step(2);
        expect_out("after_reset", 7'h3F);

        step(3);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
